// File: rtl/cpu_dbg_pkg.sv
// Shared debug-output definitions: ASCII constants, hex digit count,
// the result reporter's top FSM state type and a nibble-to-ASCII helper.
package cpu_dbg_pkg;

  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam int         HEX_DIGITS = 8;

  // Character index 0..HEX_DIGITS-1 selects a nibble, HEX_DIGITS selects LF.
  localparam int         CHAR_IDX_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND_CHAR = 2'd1,
    ST_WAIT_CHAR = 2'd2
  } tx_state_e;

  // Lowercase hex digit: 0-9 -> 0x30-0x39, a-f -> 0x61-0x66.
  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    if (nib < 4'd10) begin
      hex_ascii = 8'h30 + {4'h0, nib};
    end else begin
      hex_ascii = 8'h57 + {4'h0, nib};
    end
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer. A start request is taken while idle or in the final
// cycle of a stop bit, so the owner can chain characters with no idle gap.
// done_next flags the second-to-last stop cycle so the owner has one cycle
// to present the next character; done flags the final stop cycle.
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done_next,
  output logic       done
);

  localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [3:0]        BIT_STOP = 4'd9;

  logic             active;
  logic [3:0]       bit_idx;   // 0 start, 1..8 data, 9 stop
  logic [CNT_W-1:0] cnt;
  logic [7:0]       shreg;
  logic             load;
  logic             bit_end;

  assign bit_end   = active && (cnt == CNT_LAST);
  assign done      = bit_end && (bit_idx == BIT_STOP);
  assign done_next = active && (bit_idx == BIT_STOP) && (cnt == CNT_PRE);
  assign load      = start && (!active || done);

  // Bit timing and line control: load a frame, step bits, return to idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      active  <= 1'b0;
      bit_idx <= 4'd0;
      cnt     <= '0;
      tx      <= 1'b1;
    end else if (load) begin
      active  <= 1'b1;
      bit_idx <= 4'd0;
      cnt     <= '0;
      tx      <= 1'b0;
    end else if (active) begin
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        if (bit_idx == BIT_STOP) begin
          active  <= 1'b0;
          bit_idx <= 4'd0;
          tx      <= 1'b1;
        end else begin
          bit_idx <= bit_idx + 4'd1;
          tx      <= shreg[0];
        end
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Data shifter: LSB first, ones shifted in so the stop bit falls out last.
  always_ff @(posedge clk) begin
    if (load) begin
      shreg <= data;
    end else if (bit_end && (bit_idx != BIT_STOP)) begin
      shreg <= {1'b1, shreg[7:1]};
    end
  end

endmodule

// File: rtl/result_hex_tx.sv
// Reports a 32-bit word over UART as lowercase ASCII hex followed by LF.
// Optional feature macro RESULT_TX_ZSUPP_EN: when defined, leading zero
// nibbles are dropped (at least one digit is always sent); when undefined,
// all eight digits are sent.
module result_hex_tx
  import cpu_dbg_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_in,
  input  logic        data_valid,
  output logic        data_ready,
  output logic        tx,
  output logic        busy
);

  localparam logic [CHAR_IDX_W-1:0] LF_IDX = CHAR_IDX_W'(HEX_DIGITS);

  tx_state_e             state;
  logic [31:0]           word;
  logic [CHAR_IDX_W-1:0] char_idx;
  logic [7:0]            char_byte;
  logic                  char_start;
  logic                  char_done_next;
  logic                  char_done;
  logic                  accept;

  // Nibble at character position idx, position 0 being the most significant.
  function automatic logic [3:0] nibble_at(input logic [31:0] w,
                                           input logic [CHAR_IDX_W-1:0] idx);
    logic [4:0] shamt;
    shamt     = 5'd28 - {idx[2:0], 2'b00};
    nibble_at = 4'(w >> shamt);
  endfunction

  // Position of the most significant non-zero nibble, or the last digit
  // when the word is zero so that "0" is still reported.
  function automatic logic [CHAR_IDX_W-1:0] first_digit(input logic [31:0] w);
    logic [CHAR_IDX_W-1:0] idx;
    idx = CHAR_IDX_W'(HEX_DIGITS - 1);
    for (int i = 0; i < HEX_DIGITS; i++) begin
      if (w[i*4 +: 4] != 4'h0) begin
        idx = CHAR_IDX_W'(HEX_DIGITS - 1 - i);
      end
    end
    return idx;
  endfunction

  assign accept     = (state == ST_IDLE) && data_valid && data_ready;
  assign char_start = (state == ST_SEND_CHAR);
  assign char_byte  = (char_idx == LF_IDX) ? ASCII_LF
                                           : hex_ascii(nibble_at(word, char_idx));

  // Word capture; later changes on data_in are ignored until the next accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      word <= data_in;
    end
  end

  // Top FSM: accept a word, then request one character per frame, chaining
  // the next request into the last stop cycle so frames run back to back.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      char_idx   <= '0;
      data_ready <= 1'b1;
      busy       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
`ifdef RESULT_TX_ZSUPP_EN
            char_idx <= first_digit(data_in);
`else
            char_idx <= '0;
`endif
            state      <= ST_SEND_CHAR;
            data_ready <= 1'b0;
            busy       <= 1'b1;
          end
        end
        ST_SEND_CHAR: begin
          state <= ST_WAIT_CHAR;
        end
        ST_WAIT_CHAR: begin
          if ((char_idx != LF_IDX) && char_done_next) begin
            char_idx <= char_idx + 1'b1;
            state    <= ST_SEND_CHAR;
          end else if ((char_idx == LF_IDX) && char_done) begin
            state      <= ST_IDLE;
            data_ready <= 1'b1;
            busy       <= 1'b0;
          end
        end
        default: begin
          state      <= ST_IDLE;
          data_ready <= 1'b1;
          busy       <= 1'b0;
        end
      endcase
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_uart_tx_byte (
    .clk       (clk),
    .rst       (rst),
    .start     (char_start),
    .data      (char_byte),
    .tx        (tx),
    .done_next (char_done_next),
    .done      (char_done)
  );

endmodule

// File: tb/tb_result_hex_tx.sv
// Bench for result_hex_tx: a cycle-level waveform model derived from the
// character/framing rules, a UART receiver decoding the line, and directed
// words with hand-written expected byte strings.
module tb_result_hex_tx;

  localparam int C = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] data_in = 32'h0;
  logic        data_valid = 1'b0;
  logic        data_ready;
  logic        tx;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int falls = 0;

  always #5 clk = ~clk;

  result_hex_tx #(.CLKS_PER_BIT(C)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .tx         (tx),
    .busy       (busy)
  );

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge tx) falls <= falls + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] mb[18];
  int         mn;
  bit         mq[$];
  logic       e_tx  = 1'b1;
  logic       e_rdy = 1'b1;
  bit         on    = 1'b0;

  // Characters for one word: hex digits MSB first (optionally without
  // leading zeros), then LF.
  function automatic void model_chars(input logic [31:0] w);
    int first;
    first = 0;
`ifdef RESULT_TX_ZSUPP_EN
    first = 7;
    for (int i = 0; i < 8; i++) begin
      if (((w >> (4 * (7 - i))) & 32'hF) != 0) begin
        first = i;
        break;
      end
    end
`endif
    mn = 0;
    for (int i = first; i < 8; i++) begin
      int n;
      n = int'((w >> (4 * (7 - i))) & 32'hF);
      mb[mn] = (n < 10) ? 8'(48 + n) : 8'(87 + n);
      mn++;
    end
    mb[mn] = 8'h0A;
    mn++;
  endfunction

  always @(posedge clk) begin
    bit acc;
    if (rst) begin
      mq.delete();
      e_tx  = 1'b1;
      e_rdy = 1'b1;
      on    = 1'b1;
    end else if (on) begin
      acc = data_valid && e_rdy;
      if (mq.size() > 0) begin
        e_tx  = mq.pop_front();
        e_rdy = 1'b0;
      end else begin
        e_tx  = 1'b1;
        e_rdy = 1'b1;
      end
      if (acc) begin
        model_chars(data_in);
        for (int k = 0; k < mn; k++) begin
          for (int b = 0; b < 10; b++) begin
            bit v;
            v = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : mb[k][b-1];
            repeat (C) mq.push_back(v);
          end
        end
        e_rdy = 1'b0;
      end
    end
    #1;
    if (on) begin
      chk("tx", {31'h0, tx}, {31'h0, e_tx});
      chk("data_ready", {31'h0, data_ready}, {31'h0, e_rdy});
      chk("busy", {31'h0, busy}, {31'h0, !e_rdy});
    end
  end

  // ---------------- UART receiver ----------------
  logic [7:0] rx_q[$];

  initial begin
    forever begin
      @(negedge clk);
      if (on && !rst && tx === 1'b0) begin
        logic [7:0] b;
        for (int i = 0; i < 8; i++) begin
          repeat (C) @(negedge clk);
          b[i] = tx;
        end
        repeat (C) @(negedge clk);
        chk("stop_bit", {31'h0, tx}, 32'h1);
        rx_q.push_back(b);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [31:0] w, input bit hold, output int acc_c);
    int k;
    k = 0;
    @(negedge clk);
    data_in    = w;
    data_valid = 1'b1;
    while (data_ready !== 1'b1 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("accept_timeout", {31'h0, (k < 2000)}, 32'h1);
    @(posedge clk);
    #1;
    acc_c = cyc;
    @(negedge clk);
    if (!hold) data_valid = 1'b0;
  endtask

  task automatic wait_ready(output int r);
    int k;
    k = 0;
    while (data_ready !== 1'b1 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("ready_timeout", {31'h0, (k < 2000)}, 32'h1);
    r = cyc;
  endtask

  // Byte i of the expected string is the i-th of n bytes packed MSB first.
  task automatic expect_rx(input string nm, input int n, input logic [143:0] e);
    logic [7:0] a;
    chk({nm, "_count"}, rx_q.size(), n);
    for (int i = 0; i < n; i++) begin
      a = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
      chk($sformatf("%s_byte%0d", nm, i), {24'h0, a}, {24'h0, e[8*(n-1-i) +: 8]});
    end
    rx_q.delete();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int a, a2, r, r1, f0;

    // reset: literal state after the first edge
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_tx", {31'h0, tx}, 32'h1);
    chk("rst_ready", {31'h0, data_ready}, 32'h1);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // pin the model's character generation against literals
    model_chars(32'hDEADBEEF);
    chk("model_de_n", mn, 9);
    chk("model_de_0", {24'h0, mb[0]}, 32'h64);
    chk("model_de_2", {24'h0, mb[2]}, 32'h61);
    chk("model_de_8", {24'h0, mb[8]}, 32'h0A);
    model_chars(32'h13);
`ifdef RESULT_TX_ZSUPP_EN
    chk("model_13_n", mn, 3);
    chk("model_13_0", {24'h0, mb[0]}, 32'h31);
`else
    chk("model_13_n", mn, 9);
    chk("model_13_0", {24'h0, mb[0]}, 32'h30);
`endif

    // 0x00000013
    send(32'h13, 1'b0, a);
    wait_ready(r);
`ifdef RESULT_TX_ZSUPP_EN
    chk("dur_13", r - a - 1, 120);
    expect_rx("w13", 3, {8'h31, 8'h33, 8'h0A});
`else
    chk("dur_13", r - a - 1, 360);
    expect_rx("w13", 9, {{6{8'h30}}, 8'h31, 8'h33, 8'h0A});
`endif

    // 0xDEADBEEF
    send(32'hDEADBEEF, 1'b0, a);
    wait_ready(r);
    chk("dur_dead", r - a - 1, 360);
    expect_rx("wdead", 9, {8'h64, 8'h65, 8'h61, 8'h64, 8'h62, 8'h65, 8'h65, 8'h66, 8'h0A});

    // 0x00000000
    send(32'h0, 1'b0, a);
    wait_ready(r);
`ifdef RESULT_TX_ZSUPP_EN
    chk("dur_zero", r - a - 1, 80);
    expect_rx("wzero", 2, {8'h30, 8'h0A});
`else
    chk("dur_zero", r - a - 1, 360);
    expect_rx("wzero", 9, {{8{8'h30}}, 8'h0A});
`endif

    // back-to-back: valid held, data changes after the first acceptance
    send(32'h5, 1'b1, a);
    data_in = 32'h7;
    wait_ready(r1);
    @(posedge clk);
    #1;
    a2 = cyc;
    chk("b2b_gap", a2 - r1, 1);
    @(negedge clk);
    data_valid = 1'b0;
    wait_ready(r);
`ifdef RESULT_TX_ZSUPP_EN
    expect_rx("wb2b", 4, {8'h35, 8'h0A, 8'h37, 8'h0A});
`else
    expect_rx("wb2b", 18, {{7{8'h30}}, 8'h35, 8'h0A, {7{8'h30}}, 8'h37, 8'h0A});
`endif

    // reset during the third character's data bits
    send(32'h12345678, 1'b0, a);
    repeat (86 - (cyc - a)) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_tx", {31'h0, tx}, 32'h1);
    chk("mid_rst_ready", {31'h0, data_ready}, 32'h1);
    chk("mid_rst_busy", {31'h0, busy}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    f0 = falls;
    repeat (60) @(negedge clk);
    rx_q.delete();
    repeat (100) @(negedge clk);
    chk("mid_rst_no_start", falls - f0, 0);
    chk("mid_rst_no_chars", rx_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/result_hex_tx.md
RESULT_HEX_TX -- requirements
Module: result_hex_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, clock cycles per UART bit, legal range 2..65535.
REQ-002 SHALL have port clk  input  1  single clock, all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port data_in  input  32  word to report, typically CPU Result.
REQ-005 SHALL have port data_valid  input  1  data_in is offered.
REQ-006 SHALL have port data_ready  output  1  block can accept a word this cycle.
REQ-007 SHALL have port tx  output  1  UART 8N1 serial line, idle high.
REQ-008 SHALL have port busy  output  1  a word is being transmitted.

Function
REQ-009 SHALL accept a word on a rising edge where data_valid && data_ready, capturing data_in into an internal register.
REQ-010 SHALL drive data_ready=1 only in IDLE, so at most one word is held and no word is lost or duplicated.
REQ-011 SHALL report each accepted word as lowercase ASCII hex ('0'-'9' = 0x30-0x39, 'a'-'f' = 0x61-0x66), MSB nibble first, followed by LF (0x0A).
REQ-012 SHALL serialize each character as 8N1: start bit 0, 8 data bits LSB first, stop bit 1, each bit held for exactly CLKS_PER_BIT cycles.
REQ-013 SHALL drive tx low for the start bit of the first character starting on the edge after the accepting edge (1-cycle latency).
REQ-014 SHALL send characters back-to-back with no idle gap between one stop bit and the next start bit.
REQ-015 SHALL use top FSM states IDLE -> SEND_CHAR -> WAIT_CHAR -> (next char: SEND_CHAR | after LF: IDLE).
REQ-016 SHALL re-assert data_ready in the cycle after the final LF stop bit completes, allowing back-to-back words.
REQ-017 SHALL hold busy=1 from the edge after acceptance until the return to IDLE, and busy = !data_ready at all times.
REQ-018 SHALL ignore data_in changes after acceptance, and data_valid while busy.
REQ-019 SHALL size the bit-period counter as $clog2(CLKS_PER_BIT) bits and wrap it to 0 at CLKS_PER_BIT-1.

Reset
REQ-020 SHALL, with rst=1 at a rising edge, force tx=1, data_ready=1, busy=0, FSM=IDLE, and clear all counters on that edge.
REQ-021 SHALL abandon a partial character or word when reset occurs mid-transmission, with no characters sent after reset releases until a new word is accepted.

Configuration
REQ-022 SHALL, with RESULT_TX_ZSUPP_EN defined, suppress leading zero nibbles (matching %0h), sending at least one digit, so 0x0 sends "0\n".
REQ-023 SHALL, with RESULT_TX_ZSUPP_EN undefined, always send 8 digits plus LF, for 9 frames = 90*CLKS_PER_BIT cycles per word.

Structure
REQ-024 SHALL take ASCII_LF, the hex digit width (8 nibbles) and the top FSM state typedef from shared package cpu_dbg_pkg.
REQ-025 SHALL instantiate one sub-module uart_tx_byte (start/valid/done byte serializer, parameter CLKS_PER_BIT) that owns tx, with the top FSM selecting nibbles and characters.

Verification
REQ-026 SHALL verify reset: rst high 2 cycles -> tx=1, data_ready=1, busy=0 on the first edge.
REQ-027 SHALL verify the unsuppressed format: CLKS_PER_BIT=4, no macro, send 0x00000013 -> bytes 30 30 30 30 30 30 31 33 0A, 360 cycles, then data_ready=1.
REQ-028 SHALL verify zero suppression: macro defined, 0x00000013 -> bytes 31 33 0A (120 cycles), and 0x00000000 -> bytes 30 0A.
REQ-029 SHALL verify lowercase digits: 0xDEADBEEF -> bytes 64 65 61 64 62 65 65 66 0A.
REQ-030 SHALL verify back-to-back flow control: data_valid held high with 0x5 then 0x7 -> second word accepted exactly one cycle after the first LF stop bit completes, each word sent once.
REQ-031 SHALL verify reset mid-operation: rst asserted during the third character's data bits -> tx=1 on the next edge, data_ready=1, no further start bits.
